// File: rtl/add_seq8_if.sv
// Operand/result bundle for the byte-serial add/subtract sequencer.
// The requester drives start/sub/cin/a/b; the sequencer returns busy/done/sum/cout/ovf.
interface add_seq8_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/add_seq8.sv
// Multi-byte add/subtract sequencer: streams NBYTES bytes LSB-first through one
// shared 8-bit ripple adder, chaining the carry through a register.

module fulladder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c,
  output logic [7:0] s,
  output logic       cout
);
  logic [8:0] cy;

  assign cy[0] = c;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign s[i]    = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
  end

  assign cout = cy[8];
endmodule

module add_seq8 #(
  parameter int NBYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  add_seq8_if.slave   bus
);
  localparam int W  = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           carry;
  logic [W-1:0]   opa;
  logic [W-1:0]   opb;
  logic [W-1:0]   res;
  logic           amsb;
  logic           bmsb;

  logic [7:0]     add_s;
  logic           add_co;
  logic [W+7:0]   res_cat;
  logic [W-1:0]   res_next;

  fulladder8 u_add (
    .a    (opa[7:0]),
    .b    (opb[7:0]),
    .c    (carry),
    .s    (add_s),
    .cout (add_co)
  );

  // New byte enters at the top, so after NBYTES shifts the LSB byte sits at [7:0].
  assign res_cat  = {add_s, res};
  assign res_next = res_cat[W+7:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      carry    <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            opa      <= bus.a;
            // Subtraction is a + ~b + 1, so the carry-in is forced high.
            opb      <= bus.sub ? ~bus.b : bus.b;
            carry    <= bus.sub ? 1'b1 : bus.cin;
            amsb     <= bus.a[W-1];
            bmsb     <= bus.b[W-1] ^ bus.sub;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          res   <= res_next;
          opa   <= opa >> 8;
          opb   <= opb >> 8;
          carry <= add_co;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Results are registered on the way into DONE so they are visible with done.
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.sum  <= res_next;
            bus.cout <= add_co;
            bus.ovf  <= (amsb == bmsb) && (res_next[W-1] != amsb);
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_add_seq8.sv
// Directed and randomized checks of add_seq8 (NBYTES=4) against an arithmetic
// reference model that works on whole operands.
module tb_add_seq8;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic clk = 1'b0;
  logic rst;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] prev_sum;
  logic         prev_cout;
  logic         prev_ovf;

  add_seq8_if #(.NBYTES(NB)) bus ();

  add_seq8 #(.NBYTES(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word modular arithmetic plus a signed range test for overflow.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c,
                       output logic [W-1:0] r, output logic co, output logic ov);
    logic [W:0] full;
    longint     sa, sb, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      sr   = sa - sb;
    end else begin
      full = {1'b0, a} + {1'b0, b} + (W+1)'(c);
      sr   = sa + sb + longint'(c);
    end
    r  = full[W-1:0];
    co = full[W];
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endtask

  // Starts in cycle 0 (caller is just after an edge in IDLE) and ends in the idle cycle after done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c,
                        input string tag);
    logic [W-1:0] er;
    logic         ec, eo;
    model(a, b, s, c, er, ec, eo);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.sub   = s;
    bus.cin   = c;
    step();
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    for (int k = 1; k <= NB; k++) begin
      check({tag, "_busy"}, 64'(bus.busy), 64'd1);
      check({tag, "_nodone"}, 64'(bus.done), 64'd0);
      check({tag, "_hold_sum"}, 64'(bus.sum), 64'(prev_sum));
      check({tag, "_hold_flags"}, 64'({bus.cout, bus.ovf}), 64'({prev_cout, prev_ovf}));
      step();
    end
    check({tag, "_done"}, 64'({bus.done, bus.busy}), 64'b10);
    check({tag, "_sum"}, 64'(bus.sum), 64'(er));
    check({tag, "_cout"}, 64'(bus.cout), 64'(ec));
    check({tag, "_ovf"}, 64'(bus.ovf), 64'(eo));
    prev_sum  = er;
    prev_cout = ec;
    prev_ovf  = eo;
    step();
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb, xr;
    logic         rs, rc, xc, xo;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.cin   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    prev_sum  = '0;
    prev_cout = 1'b0;
    prev_ovf  = 1'b0;
    step();
    step();
    check("reset_outputs", 64'({bus.busy, bus.done, bus.cout, bus.ovf}), 64'd0);
    check("reset_sum", 64'(bus.sum), 64'd0);
    rst = 1'b0;
    step();

    run_op(32'h0000_0008, 32'h0000_0002, 1'b0, 1'b0, "basic_add");
    run_op(32'h0000_00F2, 32'h0000_000F, 1'b0, 1'b1, "carry_in");
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "ripple_wrap");
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "pos_ovf");
    run_op(32'h0000_000C, 32'h0000_00F2, 1'b1, 1'b1, "sub_borrow");
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, "sub_ovf");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "neg_ovf");
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, "sub_equal");

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      if (i % 6 == 0) rb = ~ra;
      if (i % 6 == 1) ra = {1'b0, ra[W-2:0]};
      run_op(ra, rb, rs, rc, "rand");
    end

    // Starts issued during RUN and DONE are dropped.
    model(32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0, xr, xc, xo);
    bus.start = 1'b1; bus.a = 32'h0000_1000; bus.b = 32'h0000_0234; bus.sub = 1'b0; bus.cin = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    bus.start = 1'b1; bus.a = 32'hAAAA_AAAA; bus.b = 32'h5555_5555;
    step();
    bus.start = 1'b0;
    step();
    step();
    bus.start = 1'b1; bus.a = 32'h0F0F_0F0F; bus.b = 32'h0101_0101;
    check("busy_start_done", 64'(bus.done), 64'd1);
    check("busy_start_sum", 64'(bus.sum), 64'(xr));
    step();
    bus.start = 1'b0;
    for (int k = 6; k <= 13; k++) begin
      check("busy_start_once", 64'({bus.done, bus.busy}), 64'd0);
      check("busy_start_hold", 64'(bus.sum), 64'(xr));
      step();
    end

    // Start held high: one operation every NBYTES+2 cycles.
    model(32'h0000_0100, 32'h0000_0023, 1'b0, 1'b1, xr, xc, xo);
    bus.start = 1'b1; bus.a = 32'h0000_0100; bus.b = 32'h0000_0023; bus.sub = 1'b0; bus.cin = 1'b1;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      step();
      check("held_done", 64'(bus.done), 64'((cyc % 6) == 5));
      check("held_busy", 64'(bus.busy), 64'(((cyc % 6) >= 1) && ((cyc % 6) <= 4)));
      if (cyc % 6 == 5) check("held_sum", 64'(bus.sum), 64'(xr));
    end
    bus.start = 1'b0;
    step();

    // Reset in the middle of RUN aborts without a done pulse.
    bus.start = 1'b1; bus.a = 32'hDEAD_BEEF; bus.b = 32'h0000_0001; bus.sub = 1'b0; bus.cin = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_busy", 64'({bus.busy, bus.done}), 64'd0);
    check("rst_mid_sum", 64'(bus.sum), 64'd0);
    check("rst_mid_flags", 64'({bus.cout, bus.ovf}), 64'd0);
    for (int k = 4; k <= 7; k++) begin
      step();
      check("rst_mid_no_done", 64'({bus.done, bus.busy}), 64'd0);
    end
    prev_sum  = '0;
    prev_cout = 1'b0;
    prev_ovf  = 1'b0;
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
